// File: rtl/matrix_mul_imag_seq_pkg.sv
// Shared types for the sequential complex matrix multiplier: element type, FSM states
// and the round-half-up / saturate helper applied to every finished accumulator.
package matrix_mul_imag_seq_pkg;

    localparam int DEF_WIDTH = 16;

    typedef struct packed {
        logic signed [DEF_WIDTH-1:0] r;
        logic signed [DEF_WIDTH-1:0] i;
    } cplx_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    typedef struct packed {
        logic signed [63:0] val;
        logic               sat;
    } rnd_t;

    // acc is a full-precision product sum; result is clamped to a width-bit signed range.
    function automatic rnd_t sat_round(input longint acc, input int width, input int frac);
        rnd_t   r;
        longint v;
        longint hi;
        longint lo;
        v = acc;
        if (frac > 0) begin
            v = (acc + (longint'(1) <<< (frac - 1))) >>> frac;
        end
        hi = (longint'(1) <<< (width - 1)) - 1;
        lo = -hi - 1;
        r.sat = 1'b0;
        if (v > hi) begin
            r.val = hi;
            r.sat = 1'b1;
        end else if (v < lo) begin
            r.val = lo;
            r.sat = 1'b1;
        end else begin
            r.val = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/matrix_mul_imag_seq_cmplx_mac.sv
// Single complex multiply-accumulate with optional conjugation of the A operand.
// sum_* is the accumulator plus the current product, so the last term is usable the same cycle.
module matrix_mul_imag_seq_cmplx_mac #(
    parameter int WIDTH = 16,
    parameter int ACC_W = 34
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [WIDTH-1:0] a_r,
    input  logic signed [WIDTH-1:0] a_i,
    input  logic signed [WIDTH-1:0] b_r,
    input  logic signed [WIDTH-1:0] b_i,
    input  logic                    conj,
    input  logic                    clr,
    input  logic                    en,
    input  logic                    last,
    output logic signed [ACC_W-1:0] sum_r,
    output logic signed [ACC_W-1:0] sum_i
);

    logic signed [2*WIDTH-1:0] p_rr;
    logic signed [2*WIDTH-1:0] p_ii;
    logic signed [2*WIDTH-1:0] p_ri;
    logic signed [2*WIDTH-1:0] p_ir;
    logic signed [ACC_W-1:0]   x_rr;
    logic signed [ACC_W-1:0]   x_ii;
    logic signed [ACC_W-1:0]   x_ri;
    logic signed [ACC_W-1:0]   x_ir;
    logic signed [ACC_W-1:0]   acc_r;
    logic signed [ACC_W-1:0]   acc_i;

    assign p_rr = (2*WIDTH)'(a_r) * (2*WIDTH)'(b_r);
    assign p_ii = (2*WIDTH)'(a_i) * (2*WIDTH)'(b_i);
    assign p_ri = (2*WIDTH)'(a_r) * (2*WIDTH)'(b_i);
    assign p_ir = (2*WIDTH)'(a_i) * (2*WIDTH)'(b_r);

    assign x_rr = ACC_W'(p_rr);
    assign x_ii = ACC_W'(p_ii);
    assign x_ri = ACC_W'(p_ri);
    assign x_ir = ACC_W'(p_ir);

    // conj(A) flips the sign of Ai in both cross terms
    always_comb begin
        if (conj) begin
            sum_r = acc_r + x_rr + x_ii;
            sum_i = acc_i + x_ri - x_ir;
        end else begin
            sum_r = acc_r + x_rr - x_ii;
            sum_i = acc_i + x_ri + x_ir;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= '0;
            acc_i <= '0;
        end else if (clr) begin
            acc_r <= '0;
            acc_i <= '0;
        end else if (en) begin
            acc_r <= last ? '0 : sum_r;
            acc_i <= last ? '0 : sum_i;
        end
    end

endmodule

// File: rtl/matrix_mul_imag_seq.sv
// Sequential complex matrix multiplier RES = op(A) * B using one time-shared complex MAC.
// state | meaning
// IDLE  | waiting for an operand set, in_ready high
// CALC  | one MAC per cycle, k inner, then n, then m
// DONE  | result held until the consumer takes it
module matrix_mul_imag_seq
    import matrix_mul_imag_seq_pkg::*;
#(
    parameter int A_N   = 2,
    parameter int A_M   = 2,
    parameter int B_N   = 2,
    parameter int B_M   = 2,
    parameter int WIDTH = DEF_WIDTH,
    parameter int FRAC  = WIDTH / 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic                                conj_a,
    input  logic [A_M-1:0][A_N-1:0][WIDTH-1:0]  matA_r,
    input  logic [A_M-1:0][A_N-1:0][WIDTH-1:0]  matA_i,
    input  logic [B_M-1:0][B_N-1:0][WIDTH-1:0]  matB_r,
    input  logic [B_M-1:0][B_N-1:0][WIDTH-1:0]  matB_i,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [B_M-1:0][A_N-1:0][WIDTH-1:0]  res_r,
    output logic [B_M-1:0][A_N-1:0][WIDTH-1:0]  res_i,
    output logic                                sat
);

    localparam int ACC_W = 2*WIDTH + $clog2(A_M) + 1;
    localparam int K_W   = (A_M > 1) ? $clog2(A_M) : 1;
    localparam int N_W   = (A_N > 1) ? $clog2(A_N) : 1;
    localparam int M_W   = (B_M > 1) ? $clog2(B_M) : 1;

    if (A_M != B_N) begin : g_dim_check
        $error("matrix_mul_imag_seq: A_M must equal B_N");
    end

    state_t state_q;
    state_t state_d;

    logic [K_W-1:0] k_q;
    logic [N_W-1:0] n_q;
    logic [M_W-1:0] m_q;

    logic [A_M-1:0][A_N-1:0][WIDTH-1:0] a_r_q;
    logic [A_M-1:0][A_N-1:0][WIDTH-1:0] a_i_q;
    logic [B_M-1:0][B_N-1:0][WIDTH-1:0] b_r_q;
    logic [B_M-1:0][B_N-1:0][WIDTH-1:0] b_i_q;
    logic                               conj_q;

    logic accept;
    logic mac_en;
    logic last_k;
    logic last_n;
    logic last_m;

    logic signed [WIDTH-1:0] op_ar;
    logic signed [WIDTH-1:0] op_ai;
    logic signed [WIDTH-1:0] op_br;
    logic signed [WIDTH-1:0] op_bi;
    logic signed [ACC_W-1:0] sum_r;
    logic signed [ACC_W-1:0] sum_i;
    rnd_t                    rnd_r;
    rnd_t                    rnd_i;
    logic                    unused_rnd_bits;

    assign last_k = (k_q == K_W'(A_M - 1));
    assign last_n = (n_q == N_W'(A_N - 1));
    assign last_m = (m_q == M_W'(B_M - 1));

    assign op_ar = a_r_q[k_q][n_q];
    assign op_ai = a_i_q[k_q][n_q];
    assign op_br = b_r_q[m_q][k_q];
    assign op_bi = b_i_q[m_q][k_q];

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        accept   = 1'b0;
        mac_en   = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                mac_en = 1'b1;
                if (last_k && last_n && last_m) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    matrix_mul_imag_seq_cmplx_mac #(
        .WIDTH (WIDTH),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .a_r   (op_ar),
        .a_i   (op_ai),
        .b_r   (op_br),
        .b_i   (op_bi),
        .conj  (conj_q),
        .clr   (accept),
        .en    (mac_en),
        .last  (last_k),
        .sum_r (sum_r),
        .sum_i (sum_i)
    );

    always_comb begin
        rnd_r = sat_round(longint'(sum_r), WIDTH, FRAC);
        rnd_i = sat_round(longint'(sum_i), WIDTH, FRAC);
    end

    assign unused_rnd_bits = ^{rnd_r.val[63:WIDTH], rnd_i.val[63:WIDTH]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q       <= '0;
            n_q       <= '0;
            m_q       <= '0;
            a_r_q     <= '0;
            a_i_q     <= '0;
            b_r_q     <= '0;
            b_i_q     <= '0;
            conj_q    <= 1'b0;
            res_r     <= '0;
            res_i     <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                a_r_q  <= matA_r;
                a_i_q  <= matA_i;
                b_r_q  <= matB_r;
                b_i_q  <= matB_i;
                conj_q <= conj_a;
                k_q    <= '0;
                n_q    <= '0;
                m_q    <= '0;
                sat    <= 1'b0;
            end else if (mac_en) begin
                if (last_k) begin
                    k_q <= '0;
                    res_r[m_q][n_q] <= rnd_r.val[WIDTH-1:0];
                    res_i[m_q][n_q] <= rnd_i.val[WIDTH-1:0];
                    if (rnd_r.sat || rnd_i.sat) begin
                        sat <= 1'b1;
                    end
                    if (last_n) begin
                        n_q <= '0;
                        m_q <= last_m ? '0 : m_q + 1'b1;
                    end else begin
                        n_q <= n_q + 1'b1;
                    end
                end else begin
                    k_q <= k_q + 1'b1;
                end
            end
            // one registered cycle after entering DONE; drops on the handoff edge
            out_valid <= (state_q == DONE) && !(out_valid && out_ready);
        end
    end

endmodule

// File: tb/tb_matrix_mul_imag_seq.sv
// Directed plus randomized bench for matrix_mul_imag_seq (2x2x2, Q8.8) against an
// arithmetic reference model of the complex matrix product.
module tb_matrix_mul_imag_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic conj_a = 1'b0;
    logic out_valid;
    logic out_ready = 1'b0;
    logic sat;
    logic [1:0][1:0][15:0] matA_r = '0;
    logic [1:0][1:0][15:0] matA_i = '0;
    logic [1:0][1:0][15:0] matB_r = '0;
    logic [1:0][1:0][15:0] matB_i = '0;
    logic [1:0][1:0][15:0] res_r;
    logic [1:0][1:0][15:0] res_i;

    int errors = 0;
    int checks = 0;

    int ar[2][2];
    int ai[2][2];
    int br[2][2];
    int bi[2][2];
    logic [15:0] er[2][2];
    logic [15:0] ei[2][2];
    logic        esat;

    matrix_mul_imag_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .conj_a    (conj_a),
        .matA_r    (matA_r),
        .matA_i    (matA_i),
        .matB_r    (matB_r),
        .matB_i    (matB_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res_r     (res_r),
        .res_i     (res_i),
        .sat       (sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [16:0] round_sat16(input longint v);
        longint q;
        q = (v + 128) >>> 8;
        if (q > 32767) return {1'b1, 16'h7FFF};
        if (q < -32768) return {1'b1, 16'h8000};
        return {1'b0, q[15:0]};
    endfunction

    task automatic model(input logic cj);
        longint      sr;
        longint      si;
        longint      s;
        logic [16:0] t;
        s = cj ? -1 : 1;
        esat = 1'b0;
        for (int n = 0; n < 2; n++) begin
            for (int m = 0; m < 2; m++) begin
                sr = 0;
                si = 0;
                for (int k = 0; k < 2; k++) begin
                    sr += longint'(ar[n][k]) * br[k][m] - s * longint'(ai[n][k]) * bi[k][m];
                    si += longint'(ar[n][k]) * bi[k][m] + s * longint'(ai[n][k]) * br[k][m];
                end
                t = round_sat16(sr);
                er[n][m] = t[15:0];
                esat |= t[16];
                t = round_sat16(si);
                ei[n][m] = t[15:0];
                esat |= t[16];
            end
        end
    endtask

    task automatic pack_ops();
        for (int n = 0; n < 2; n++) begin
            for (int m = 0; m < 2; m++) begin
                matA_r[m][n] = ar[n][m][15:0];
                matA_i[m][n] = ai[n][m][15:0];
                matB_r[m][n] = br[n][m][15:0];
                matB_i[m][n] = bi[n][m][15:0];
            end
        end
    endtask

    task automatic fill_all(input int var_ar, input int var_ai, input int var_br, input int var_bi);
        for (int n = 0; n < 2; n++) begin
            for (int m = 0; m < 2; m++) begin
                ar[n][m] = var_ar;
                ai[n][m] = var_ai;
                br[n][m] = var_br;
                bi[n][m] = var_bi;
            end
        end
    endtask

    task automatic rand_ops(input int span);
        for (int n = 0; n < 2; n++) begin
            for (int m = 0; m < 2; m++) begin
                ar[n][m] = int'($urandom_range(0, 2*span - 1)) - span;
                ai[n][m] = int'($urandom_range(0, 2*span - 1)) - span;
                br[n][m] = int'($urandom_range(0, 2*span - 1)) - span;
                bi[n][m] = int'($urandom_range(0, 2*span - 1)) - span;
            end
        end
    endtask

    task automatic check_res(input string tag);
        for (int n = 0; n < 2; n++) begin
            for (int m = 0; m < 2; m++) begin
                check($sformatf("%s_res_r%0d%0d", tag, n, m), 32'(res_r[m][n]), 32'(er[n][m]));
                check($sformatf("%s_res_i%0d%0d", tag, n, m), 32'(res_i[m][n]), 32'(ei[n][m]));
            end
        end
        check({tag, "_sat"}, 32'(sat), 32'(esat));
    endtask

    // Accept one operand set, scramble the inputs, wait for out_valid and check the result.
    task automatic run_txn(input logic cj, input string tag);
        int cycles;
        pack_ops();
        model(cj);
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        conj_a   = cj;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        conj_a   = ~cj;
        matA_r   = {$urandom, $urandom};
        matB_i   = {$urandom, $urandom};
        cycles   = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!out_valid && cycles < 40);
        check({tag, "_latency"}, 32'(cycles), 32'd9);
        check_res(tag);
    endtask

    task automatic release_res(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sat", 32'(sat), 32'd0);
        check("rst_res_r", 32'(res_r), 32'd0);
        check("rst_res_i", 32'(res_i), 32'd0);
        rst_n = 1'b1;

        fill_all(512, 512, 512, 512);
        run_txn(1'b0, "t1");
        check("t1_res_i_const", 32'(res_i[1][0]), 32'h1000);
        check("t1_res_r_const", 32'(res_r[0][1]), 32'h0000);
        release_res("t1");

        run_txn(1'b1, "t2");
        check("t2_res_r_const", 32'(res_r[1][1]), 32'h1000);
        release_res("t2");

        fill_all(25600, 0, 25600, 0);
        run_txn(1'b0, "t3p");
        check("t3p_res_r_const", 32'(res_r[0][0]), 32'h7FFF);
        release_res("t3p");
        fill_all(-25600, 0, 25600, 0);
        run_txn(1'b0, "t3n");
        check("t3n_res_r_const", 32'(res_r[1][0]), 32'h8000);
        release_res("t3n");

        fill_all(0, 0, 0, 0);
        ar[0][0] = 1;
        br[0][0] = 128;
        run_txn(1'b0, "t4");
        check("t4_res_r_const", 32'(res_r[0][0]), 32'h0001);
        release_res("t4");

        rand_ops(2048);
        run_txn(1'b1, "t5");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = i[0];
            @(posedge clk);
            #1;
            check("t5_hold_out_valid", 32'(out_valid), 32'd1);
            check("t5_hold_in_ready", 32'(in_ready), 32'd0);
            check_res("t5_hold");
        end
        in_valid = 1'b0;
        release_res("t5");

        rand_ops(32768);
        pack_ops();
        @(negedge clk);
        conj_a   = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_in_ready", 32'(in_ready), 32'd1);
        check("t6_rst_out_valid", 32'(out_valid), 32'd0);
        check("t6_rst_sat", 32'(sat), 32'd0);
        check("t6_rst_res_r", 32'(res_r), 32'd0);
        check("t6_rst_res_i", 32'(res_i), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rand_ops(4096);
        run_txn(1'b0, "t6");
        release_res("t6");

        for (int t = 0; t < 8; t++) begin
            rand_ops(t[0] ? 32768 : 3000);
            run_txn(t[1], $sformatf("rnd%0d", t));
            release_res($sformatf("rnd%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
